// File: rtl/dsp_pack_pkg.sv
// dsp_pack_pkg: INT8 type, packing widths and
// lane unpack helpers for the packed INT8 MAC.
package dsp_pack_pkg;

  typedef logic signed [7:0] int8_t;

  localparam int WIDE = 64;
  typedef logic signed [WIDE-1:0] wide_t;

  function automatic int shift_w(int max_len);
    return 16 + $clog2(max_len);
  endfunction

  function automatic int acc_w(int max_len);
    return 2 * shift_w(max_len) + 2;
  endfunction

  function automatic int lane_w(int max_len);
    return shift_w(max_len) + 1;
  endfunction

  function automatic wide_t unpack_lo(
    wide_t acc,
    int    shift
  );
    return (acc <<< (WIDE - shift)) >>> (WIDE - shift);
  endfunction

  // hi lane borrows one whenever the lo lane went negative
  function automatic wide_t unpack_hi(
    wide_t acc,
    int    shift
  );
    wide_t b;
    b = wide_t'({{(WIDE-1){1'b0}}, acc[shift-1]});
    return (acc >>> shift) + b;
  endfunction

endpackage

// File: rtl/dsp_pack_mult.sv
// dsp_pack_mult: S1/S2 packed multiply with stall enable.
// Pre-adder packs both lanes, one multiplier serves both.
module dsp_pack_mult
  import dsp_pack_pkg::*;
#(
  parameter int SHIFT = 18,
  parameter int ACC_W = 38
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [7:0]       act_a,
  input  logic signed [7:0]       act_b,
  input  logic signed [7:0]       weight,
  output logic signed [ACC_W-1:0] prod
);

  localparam int PW = SHIFT + 9;

  logic signed [PW-1:0] pk_d;
  logic signed [PW-1:0] pk;
  int8_t                w1;

  always_comb begin
    pk_d = (PW'(act_a) <<< SHIFT) + PW'(act_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk   <= '0;
      w1   <= '0;
      prod <= '0;
    end else if (en) begin
      pk   <= pk_d;
      w1   <= weight;
      prod <= ACC_W'(pk) * ACC_W'(w1);
    end
  end

endmodule

// File: rtl/dsp_int8_packed_mac.sv
// dsp_int8_packed_mac: dual-lane INT8 dot product on one multiplier.
// Define DSP_PACK_RELU_EN to clamp negative lane results to zero.
module dsp_int8_packed_mac
  import dsp_pack_pkg::*;
#(
  parameter  int MAX_LEN = 4,
  localparam int GUARD   = $clog2(MAX_LEN),
  localparam int SHIFT   = shift_w(MAX_LEN),
  localparam int LANE_W  = lane_w(MAX_LEN),
  localparam int ACC_W   = acc_w(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic signed [7:0]        act_a,
  input  logic signed [7:0]        act_b,
  input  logic signed [7:0]        weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [LANE_W-1:0] out_a,
  output logic signed [LANE_W-1:0] out_b,
  output logic                     err_len
);

  localparam int CW = GUARD + 1;

  logic                     stall;
  logic                     accept;
  logic                     at_max;
  logic                     eff_last;
  logic                     forced;
  logic [CW-1:0]            cnt;
  logic                     v1, l1, v2, l2;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [LANE_W-1:0] res_a;
  logic signed [LANE_W-1:0] res_b;

  // only a finished vector waiting on a busy output blocks the pipe
  assign stall    = out_valid && !out_ready && v2 && l2;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign at_max   = cnt == CW'(MAX_LEN - 1);
  assign eff_last = in_last || at_max;
  assign forced   = at_max && !in_last;
  assign acc_sum  = acc + prod;

  dsp_pack_mult #(
    .SHIFT (SHIFT),
    .ACC_W (ACC_W)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (!stall),
    .act_a  (act_a),
    .act_b  (act_b),
    .weight (weight),
    .prod   (prod)
  );

  always_comb begin
    res_a = LANE_W'(unpack_hi(wide_t'(acc_sum), SHIFT));
    res_b = LANE_W'(unpack_lo(wide_t'(acc_sum), SHIFT));
`ifdef DSP_PACK_RELU_EN
    if (res_a[LANE_W-1]) res_a = '0;
    if (res_b[LANE_W-1]) res_b = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      err_len <= 1'b0;
      v1      <= 1'b0;
      l1      <= 1'b0;
      v2      <= 1'b0;
      l2      <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= eff_last ? '0 : cnt + CW'(1);
        if (forced) err_len <= 1'b1;
      end
      if (!stall) begin
        v1 <= accept;
        l1 <= accept && eff_last;
        v2 <= v1;
        l2 <= l1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (v2 && !stall) begin
        if (l2) begin
          acc       <= '0;
          out_valid <= 1'b1;
          out_a     <= res_a;
          out_b     <= res_b;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule
